// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and helpers for the sipo_frame_shifter slice (PARITY_EN aware)
package sipo_pkg;

    // Output holding register occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    // Widest frame the parity helper accepts; narrower words are zero-extended
    localparam int SIPO_MAX_WIDTH = 64;

    // Bits needed to count 0..width inclusive
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Even-parity check: 1 when data bits plus the parity bit hold an odd number of ones
    function automatic logic even_parity_err(input logic [SIPO_MAX_WIDTH-1:0] data,
                                             input logic                      pbit);
        return (^data) ^ pbit;
    endfunction

endpackage

// File: rtl/sipo_frame_buffer.sv
// rtl/sipo_frame_buffer.sv - frame holding register with valid/ready handshake and sticky overrun
module sipo_frame_buffer
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_done,
    input  logic [WIDTH-1:0] done_word,
    input  logic             done_perr,
    input  logic             frame_ready,
    output logic [WIDTH-1:0] frame_word,
    output logic             frame_valid,
    output logic             overrun,
    output logic             parity_err
);

    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] frame_word_q, frame_word_d;
    logic             overrun_q, overrun_d;
    logic             parity_err_q, parity_err_d;

    // Next-state of the holding register: capture when the slot is free or being drained,
    // otherwise keep the old frame and flag the dropped one
    always_comb begin
        state_d      = state_q;
        frame_word_d = frame_word_q;
        overrun_d    = overrun_q;
        parity_err_d = parity_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (frame_done) begin
                    state_d      = ST_FULL;
                    frame_word_d = done_word;
                    parity_err_d = done_perr;
                end
            end
            ST_FULL: begin
                if (frame_done) begin
                    if (frame_ready) begin
                        frame_word_d = done_word;
                        parity_err_d = done_perr;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (frame_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Buffer state machine registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            frame_word_q <= '0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_word_q <= frame_word_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign frame_word  = frame_word_q;
    assign frame_valid = (state_q == ST_FULL);
    assign overrun     = overrun_q;
    assign parity_err  = parity_err_q;

endmodule

// File: rtl/sipo_frame_shifter.sv
// rtl/sipo_frame_shifter.sv - framed SIPO/PISO shift register; PARITY_EN adds a trailing even-parity bit
module sipo_frame_shifter
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           shift_en,
    input  logic                           sdata,
    input  logic                           load,
    input  logic [WIDTH-1:0]               pin,
    input  logic                           abort,
    output logic [WIDTH-1:0]               pout,
    output logic                           sout,
    output logic [cnt_width(WIDTH)-1:0]    bit_cnt,
    output logic [WIDTH-1:0]               frame_word,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic                           overrun,
    output logic                           parity_err
);

    localparam int CW = cnt_width(WIDTH);
`ifdef PARITY_EN
    // Count reaches WIDTH: the extra shift carries the parity bit
    localparam int LAST_CNT = WIDTH;
`else
    localparam int LAST_CNT = WIDTH - 1;
`endif

    logic [WIDTH-1:0] pout_q, pout_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             frame_done;
    logic             frame_perr;

`ifdef PARITY_EN
    logic [SIPO_MAX_WIDTH-1:0] pout_ext;

    // Zero-extend the data word for the shared parity helper
    always_comb begin
        pout_ext              = '0;
        pout_ext[WIDTH-1:0]   = pout_q;
    end
`endif

    // Shift register contents after one serial step in the configured direction
    always_comb begin
        if (LSB_FIRST) begin
            shifted = {sdata, pout_q[WIDTH-1:1]};
        end else begin
            shifted = {pout_q[WIDTH-2:0], sdata};
        end
    end

    // Load > abort > shift; the final shift of a frame wraps the counter and raises frame_done
    always_comb begin
        pout_d     = pout_q;
        bit_cnt_d  = bit_cnt_q;
        frame_done = 1'b0;
        frame_perr = 1'b0;
        if (load) begin
            pout_d    = pin;
            bit_cnt_d = '0;
        end else if (abort) begin
            bit_cnt_d = '0;
        end else if (shift_en) begin
            if (bit_cnt_q == CW'(LAST_CNT)) begin
                frame_done = 1'b1;
                bit_cnt_d  = '0;
`ifdef PARITY_EN
                // Parity bit is consumed here and never enters the data word
                frame_perr = even_parity_err(pout_ext, sdata);
`else
                pout_d     = shifted;
`endif
            end else begin
                pout_d    = shifted;
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
    end

    // Shift register and frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pout_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            pout_q    <= pout_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The completed word is the register value the final shift produces
    sipo_frame_buffer #(
        .WIDTH (WIDTH)
    ) u_buffer (
        .clk         (clk),
        .reset       (reset),
        .frame_done  (frame_done),
        .done_word   (pout_d),
        .done_perr   (frame_perr),
        .frame_ready (frame_ready),
        .frame_word  (frame_word),
        .frame_valid (frame_valid),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    assign pout    = pout_q;
    assign bit_cnt = bit_cnt_q;
    assign sout    = LSB_FIRST ? pout_q[0] : pout_q[WIDTH-1];

endmodule

// File: tb/tb_sipo_frame_shifter.sv
// tb/tb_sipo_frame_shifter.sv - scoreboard bench for both shift directions (PARITY_EN aware)
module tb_sipo_frame_shifter;

    localparam int W = 8;
`ifdef PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         shift_en = 1'b0, sdata = 1'b0, load = 1'b0, abort = 1'b0, frame_ready = 1'b0;
    logic [W-1:0] pin = '0;

    logic [W-1:0] pout_m, fw_m, pout_l, fw_l;
    logic [3:0]   cnt_m, cnt_l;
    logic         sout_m, fv_m, ovr_m, pe_m, sout_l, fv_l, ovr_l, pe_l;

    sipo_frame_shifter #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset(reset), .shift_en(shift_en), .sdata(sdata), .load(load),
        .pin(pin), .abort(abort), .pout(pout_m), .sout(sout_m), .bit_cnt(cnt_m),
        .frame_word(fw_m), .frame_valid(fv_m), .frame_ready(frame_ready),
        .overrun(ovr_m), .parity_err(pe_m));

    sipo_frame_shifter #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .shift_en(shift_en), .sdata(sdata), .load(load),
        .pin(pin), .abort(abort), .pout(pout_l), .sout(sout_l), .bit_cnt(cnt_l),
        .frame_word(fw_l), .frame_valid(fv_l), .frame_ready(frame_ready),
        .overrun(ovr_l), .parity_err(pe_l));

    typedef struct {
        logic [W-1:0] wm;
        logic [W-1:0] wl;
    } frame_t;

    frame_t exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    // Reference model: bits collected so far, plus one holding slot
    bit           bits_q[$];
    bit           m_full = 0, m_ovr = 0, m_perr = 0;
    logic [W-1:0] m_wm = '0, m_wl = '0;
    // Snapshot of the model matching the DUT state between two edges
    bit           s_full = 0, s_ovr = 0, s_perr = 0;
    int           s_cnt = 0;
    bit           mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input bit ab, input bit sh,
                        input bit sd, input bit rdy, input logic [W-1:0] p);
        logic [W-1:0] nwm, nwl;
        bit           np, done;
        @(posedge clk);
        #1;
        reset = rst; load = ld; abort = ab; shift_en = sh; sdata = sd;
        frame_ready = rdy; pin = p;
        s_full = m_full; s_ovr = m_ovr; s_perr = m_perr; s_cnt = bits_q.size();
        done = 0; nwm = '0; nwl = '0; np = 0;
        if (rst) begin
            bits_q.delete();
            m_full = 0; m_ovr = 0; m_perr = 0; m_wm = '0; m_wl = '0;
        end else begin
            if (m_full && rdy) exp_q.push_back('{wm: m_wm, wl: m_wl});
            if (ld || ab) begin
                bits_q.delete();
            end else if (sh) begin
                bits_q.push_back(sd);
                if (bits_q.size() == FLEN) begin
                    for (int i = 0; i < W; i++) begin
                        nwm    = {nwm[W-2:0], bits_q[i]};
                        nwl[i] = bits_q[i];
                    end
`ifdef PARITY_EN
                    np = (^nwm) ^ bits_q[W];
`endif
                    bits_q.delete();
                    done = 1;
                end
            end
            if (done) begin
                if (!m_full || rdy) begin
                    m_full = 1; m_wm = nwm; m_wl = nwl; m_perr = np;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_full && rdy) begin
                m_full = 0;
            end
        end
        mon_en = 1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 0, rdy, '0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, '0);
    endtask

    // Data sent MSB first; rdy_last applies only to the frame's final shift
    task automatic shift_frame(input logic [W-1:0] d, input bit pbit,
                               input bit rdy_body, input bit rdy_last);
        for (int i = 0; i < FLEN; i++) begin
            step(0, 0, 0, 1, (i < W) ? d[W-1-i] : pbit,
                 (i == FLEN - 1) ? rdy_last : rdy_body, '0);
        end
    endtask

    // Monitor: compare handshake state every cycle, pop the scoreboard on each transfer
    always @(negedge clk) begin
        if (mon_en) begin
            chk("frame_valid_msb", 32'(fv_m), 32'(s_full));
            chk("frame_valid_lsb", 32'(fv_l), 32'(s_full));
            chk("overrun_msb", 32'(ovr_m), 32'(s_ovr));
            chk("overrun_lsb", 32'(ovr_l), 32'(s_ovr));
            chk("bit_cnt_msb", 32'(cnt_m), 32'(s_cnt));
            chk("bit_cnt_lsb", 32'(cnt_l), 32'(s_cnt));
            chk("parity_err", 32'(pe_m), 32'(s_perr));
            if (fv_m && frame_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'(1), 32'(0));
                end else begin
                    frame_t f;
                    f = exp_q.pop_front();
                    chk("sb_frame_word_msb", 32'(fw_m), 32'(f.wm));
                    chk("sb_frame_word_lsb", 32'(fw_l), 32'(f.wl));
                end
            end
        end
    end

    initial begin
        logic [7:0] sout_pat;
        sout_pat = 8'b1000_0001;

        // Reset state
        do_reset();
        idle(0);
        chk("rst_pout", 32'(pout_m), 32'(0));
        chk("rst_frame_word", 32'(fw_m), 32'(0));
        chk("rst_sout", 32'(sout_m), 32'(0));

        // MSB-first and LSB-first assembly of 1,0,1,1,0,0,1,0
        shift_frame(8'hB2, ^8'hB2, 1, 1);
        idle(1);
        chk("b2_pout_msb", 32'(pout_m), 32'h000000B2);
        chk("b2_pout_lsb", 32'(pout_l), 32'h0000004D);
        chk("b2_valid", 32'(fv_m), 32'(1));
        chk("b2_word_msb", 32'(fw_m), 32'h000000B2);
        chk("b2_word_lsb", 32'(fw_l), 32'h0000004D);
        chk("b2_overrun", 32'(ovr_m), 32'(0));
        idle(1);
        chk("b2_valid_pulse", 32'(fv_m), 32'(0));

        // Overrun: second frame dropped while the first is held
        do_reset();
        shift_frame(8'hA5, ^8'hA5, 0, 0);
        shift_frame(8'h3C, ^8'h3C, 0, 0);
        idle(0);
        chk("ovr_word_kept", 32'(fw_m), 32'h000000A5);
        chk("ovr_sticky", 32'(ovr_m), 32'(1));
        idle(1);
        idle(0);
        chk("ovr_valid_fell", 32'(fv_m), 32'(0));
        chk("ovr_still_set", 32'(ovr_m), 32'(1));

        // Abort discards a partial frame
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1'($urandom), 0, '0);
        step(0, 0, 1, 0, 0, 0, '0);
        shift_frame(8'hFF, ^8'hFF, 0, 0);
        idle(0);
        chk("abort_word", 32'(fw_m), 32'h000000FF);
        chk("abort_valid", 32'(fv_m), 32'(1));
        idle(1);

        // Parallel load then serial out
        step(0, 1, 0, 0, 0, 1, 8'h81);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, 0, 1, '0);
            chk("piso_sout_msb", 32'(sout_m), 32'(sout_pat[7-i]));
            chk("piso_sout_lsb", 32'(sout_l), 32'(sout_pat[i]));
        end
        idle(1);
        idle(1);

        // Reset mid-frame with a held frame
        do_reset();
        shift_frame(8'h5A, ^8'h5A, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, '0);
        idle(0);
        chk("mid_bit_cnt", 32'(cnt_m), 32'(4));
        chk("mid_valid", 32'(fv_m), 32'(1));
        do_reset();
        idle(0);
        chk("mid_rst_pout", 32'(pout_m), 32'(0));
        chk("mid_rst_cnt", 32'(cnt_m), 32'(0));
        chk("mid_rst_word", 32'(fw_m), 32'(0));
        chk("mid_rst_valid", 32'(fv_m), 32'(0));

        // Consumer accepts on the same edge a new frame completes
        shift_frame(8'hC3, ^8'hC3, 0, 0);
        shift_frame(8'h69, ^8'h69, 0, 1);
        idle(0);
        chk("coin_valid", 32'(fv_m), 32'(1));
        chk("coin_word", 32'(fw_m), 32'h00000069);
        chk("coin_overrun", 32'(ovr_m), 32'(0));
        idle(1);
        idle(0);

`ifdef PARITY_EN
        // Parity bit checked and registered with the word
        do_reset();
        shift_frame(8'h07, 1'b1, 0, 0);
        idle(0);
        chk("par_ok_word", 32'(fw_m), 32'h00000007);
        chk("par_ok_err", 32'(pe_m), 32'(0));
        idle(1);
        shift_frame(8'h07, 1'b0, 0, 0);
        idle(0);
        chk("par_bad_err", 32'(pe_m), 32'(1));
        idle(1);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 75),
                 1'($urandom),
                 ($urandom_range(0, 99) < 45),
                 W'($urandom));
        end
        idle(1);
        idle(1);
        idle(1);
        chk("sb_drained", 32'(exp_q.size()), 32'(0));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
